// File: rtl/e203_ifu_flush_redirect_if.sv
// rtl/e203_ifu_flush_redirect_if.sv - flush request, fetch tracking and redirect handshake bundle
interface e203_ifu_flush_redirect_if #(
  parameter int PC_SIZE = 32,
  parameter int CNT_W   = 2
);
  logic               brchmis_flush_req;
  logic [PC_SIZE-1:0] brchmis_flush_add_op1;
  logic [PC_SIZE-1:0] brchmis_flush_add_op2;
  logic               brchmis_flush_ack;
  logic               excp_flush_req;
  logic [PC_SIZE-1:0] excp_flush_pc;
  logic               excp_flush_ack;
  logic               ifu_req_hsk;
  logic               ifu_rsp_hsk;
  logic               ifu_req_block;
  logic               ifu_rsp_drop;
  logic               redir_valid;
  logic [PC_SIZE-1:0] redir_pc;
  logic               redir_ready;
  logic [CNT_W-1:0]   outs_cnt;
  logic               flush_busy;

  modport master (
    output brchmis_flush_req, brchmis_flush_add_op1, brchmis_flush_add_op2,
    input  brchmis_flush_ack,
    output excp_flush_req, excp_flush_pc,
    input  excp_flush_ack,
    output ifu_req_hsk, ifu_rsp_hsk,
    input  ifu_req_block, ifu_rsp_drop,
    input  redir_valid, redir_pc,
    output redir_ready,
    input  outs_cnt, flush_busy
  );

  modport slave (
    input  brchmis_flush_req, brchmis_flush_add_op1, brchmis_flush_add_op2,
    output brchmis_flush_ack,
    input  excp_flush_req, excp_flush_pc,
    output excp_flush_ack,
    input  ifu_req_hsk, ifu_rsp_hsk,
    output ifu_req_block, ifu_rsp_drop,
    output redir_valid, redir_pc,
    input  redir_ready,
    output outs_cnt, flush_busy
  );
endinterface

// File: rtl/e203_ifu_flush_redirect.sv
// rtl/e203_ifu_flush_redirect.sv - flush arbitration, wrong-path response drain and redirect PC
module e203_ifu_flush_redirect #(
  parameter int PC_SIZE    = 32,
  parameter int OUTS_DEPTH = 2,
  parameter int CNT_W      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  e203_ifu_flush_redirect_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    REDIR = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUTS_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   outs_cnt_q, outs_nxt;
  logic [CNT_W-1:0]   drop_cnt_q;
  logic [PC_SIZE-1:0] redir_pc_q;
  logic [PC_SIZE-1:0] brchmis_sum;
  logic [PC_SIZE-1:0] brchmis_tgt;
  logic               excp_ack, brchmis_ack, accept;

  // Post-cycle outstanding count; a response at zero is ignored rather than wrapping.
  always_comb begin
    outs_nxt = outs_cnt_q;
    if (bus.ifu_req_hsk && !bus.ifu_rsp_hsk)
      outs_nxt = outs_cnt_q + ONE_C;
    else if (!bus.ifu_req_hsk && bus.ifu_rsp_hsk && (outs_cnt_q != '0))
      outs_nxt = outs_cnt_q - ONE_C;
  end

  assign brchmis_sum = bus.brchmis_flush_add_op1 + bus.brchmis_flush_add_op2;
  assign brchmis_tgt = {brchmis_sum[PC_SIZE-1:1], 1'b0};

  always_comb begin
    state_d     = state_q;
    excp_ack    = 1'b0;
    brchmis_ack = 1'b0;
    case (state_q)
      IDLE: begin
        excp_ack    = bus.excp_flush_req;
        brchmis_ack = bus.brchmis_flush_req & ~bus.excp_flush_req;
        if (excp_ack || brchmis_ack)
          state_d = (outs_nxt != '0) ? DRAIN : REDIR;
      end
      DRAIN: begin
        if (bus.ifu_rsp_hsk && (drop_cnt_q == ONE_C))
          state_d = REDIR;
      end
      REDIR: begin
        if (bus.redir_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      excp_ack    = 1'b0;
      brchmis_ack = 1'b0;
    end
  end

  assign accept = excp_ack | brchmis_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      outs_cnt_q <= '0;
      drop_cnt_q <= '0;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      outs_cnt_q <= outs_nxt;
      if (accept) begin
        drop_cnt_q <= outs_nxt;
        redir_pc_q <= excp_ack ? bus.excp_flush_pc : brchmis_tgt;
      end else if ((state_q == DRAIN) && bus.ifu_rsp_hsk) begin
        drop_cnt_q <= drop_cnt_q - ONE_C;
      end
    end
  end

  assign bus.excp_flush_ack    = excp_ack;
  assign bus.brchmis_flush_ack = brchmis_ack;
  assign bus.ifu_rsp_drop      = (state_q == DRAIN);
  assign bus.redir_valid       = (state_q == REDIR);
  assign bus.redir_pc          = redir_pc_q;
  assign bus.flush_busy        = (state_q != IDLE);
  assign bus.ifu_req_block     = (state_q != IDLE) | (outs_cnt_q == DEPTH_C);
  assign bus.outs_cnt          = outs_cnt_q;

endmodule

// File: tb/tb_e203_ifu_flush_redirect.sv
// tb/tb_e203_ifu_flush_redirect.sv - randomized and directed bench with behavioural flush model
module tb_e203_ifu_flush_redirect;

  logic clk = 1'b0;
  logic rst = 1'b1;

  e203_ifu_flush_redirect_if #(.PC_SIZE(32), .CNT_W(2)) bus ();

  e203_ifu_flush_redirect #(.PC_SIZE(32), .OUTS_DEPTH(2), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: fetches in flight, wrong-path responses still owed, and whether a redirect is owed.
  int          m_outs;
  int          m_drops;
  bit          m_pending;
  logic [31:0] m_target;

  bit exp_excp_ack, exp_br_ack, exp_valid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] br_target(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
    s[0] = 1'b0;
    return s;
  endfunction

  task automatic model_check();
    exp_excp_ack = !rst && !m_pending && bus.excp_flush_req;
    exp_br_ack   = !rst && !m_pending && bus.brchmis_flush_req && !bus.excp_flush_req;
    exp_valid    = m_pending && (m_drops == 0);
    check("excp_ack",  bus.excp_flush_ack,    exp_excp_ack);
    check("br_ack",    bus.brchmis_flush_ack, exp_br_ack);
    check("req_block", bus.ifu_req_block,     m_pending || (m_outs == 2));
    check("rsp_drop",  bus.ifu_rsp_drop,      m_drops > 0);
    check("redir_vld", bus.redir_valid,       exp_valid);
    check("busy",      bus.flush_busy,        m_pending);
    check("outs_cnt",  bus.outs_cnt,          m_outs);
    if (exp_valid) check("redir_pc", bus.redir_pc, m_target);
  endtask

  task automatic model_update();
    int n;
    if (rst) begin
      m_outs = 0; m_drops = 0; m_pending = 0;
    end else begin
      n = m_outs + int'(bus.ifu_req_hsk) - int'(bus.ifu_rsp_hsk);
      if (n < 0) n = 0;
      if (m_drops > 0 && bus.ifu_rsp_hsk) m_drops--;
      if (exp_valid && bus.redir_ready) m_pending = 0;
      if (exp_excp_ack) begin
        m_pending = 1; m_drops = n; m_target = bus.excp_flush_pc;
      end else if (exp_br_ack) begin
        m_pending = 1; m_drops = n;
        m_target = br_target(bus.brchmis_flush_add_op1, bus.brchmis_flush_add_op2);
      end
      m_outs = n;
    end
  endtask

  task automatic step();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.brchmis_flush_req = 1'b0;
    bus.excp_flush_req    = 1'b0;
    bus.ifu_req_hsk       = 1'b0;
    bus.ifu_rsp_hsk       = 1'b0;
    bus.redir_ready       = 1'b0;
  endtask

  int ndrop;

  initial begin
    idle_inputs();
    bus.brchmis_flush_add_op1 = '0;
    bus.brchmis_flush_add_op2 = '0;
    bus.excp_flush_pc         = '0;
    m_outs = 0; m_drops = 0; m_pending = 0; m_target = '0;
    @(posedge clk);
    @(negedge clk);

    // Reset with both requests and a fetch handshake asserted
    rst = 1'b1;
    bus.excp_flush_req = 1'b1; bus.brchmis_flush_req = 1'b1; bus.ifu_req_hsk = 1'b1;
    #1 check("rst_excp_ack", bus.excp_flush_ack, 1'b0);
    check("rst_br_ack", bus.brchmis_flush_ack, 1'b0);
    step();
    step();
    rst = 1'b0;
    idle_inputs();
    #1 check("rst_outs", bus.outs_cnt, 2'd0);
    check("rst_valid", bus.redir_valid, 1'b0);
    check("rst_block", bus.ifu_req_block, 1'b0);
    step();

    // Plain branch-mispredict flush with a stalled PC generator
    bus.brchmis_flush_req = 1'b1;
    bus.brchmis_flush_add_op1 = 32'h8000_0100;
    bus.brchmis_flush_add_op2 = 32'h0000_0010;
    #1 check("plain_ack", bus.brchmis_flush_ack, 1'b1);
    step();
    bus.brchmis_flush_req = 1'b0;
    check("plain_valid", bus.redir_valid, 1'b1);
    check("plain_pc", bus.redir_pc, 32'h8000_0110);
    step();
    check("plain_pc_hold", bus.redir_pc, 32'h8000_0110);
    step();
    bus.redir_ready = 1'b1;
    step();
    bus.redir_ready = 1'b0;
    check("plain_idle", bus.flush_busy, 1'b0);

    // Simultaneous requests: exception first, branch flush afterwards
    bus.excp_flush_req = 1'b1; bus.excp_flush_pc = 32'h8000_0040;
    bus.brchmis_flush_req = 1'b1;
    bus.brchmis_flush_add_op1 = 32'h0000_1000; bus.brchmis_flush_add_op2 = 32'h0000_0020;
    #1 check("sim_excp_ack", bus.excp_flush_ack, 1'b1);
    check("sim_br_ack", bus.brchmis_flush_ack, 1'b0);
    step();
    bus.excp_flush_req = 1'b0;
    bus.redir_ready = 1'b1;
    check("sim_pc", bus.redir_pc, 32'h8000_0040);
    #1 check("sim_br_wait", bus.brchmis_flush_ack, 1'b0);
    step();
    #1 check("sim_br_late", bus.brchmis_flush_ack, 1'b1);
    step();
    bus.brchmis_flush_req = 1'b0;
    check("sim_br_pc", bus.redir_pc, 32'h0000_1020);
    step();
    bus.redir_ready = 1'b0;

    // Drain: two outstanding plus one accepted in the flush cycle
    bus.ifu_req_hsk = 1'b1;
    step();
    step();
    bus.brchmis_flush_req = 1'b1;
    bus.brchmis_flush_add_op1 = 32'h0000_0100; bus.brchmis_flush_add_op2 = 32'h0000_0003;
    #1 check("drain_ack", bus.brchmis_flush_ack, 1'b1);
    step();
    bus.brchmis_flush_req = 1'b0; bus.ifu_req_hsk = 1'b0;
    ndrop = 0;
    for (int c = 0; c < 20 && ndrop < 3; c++) begin
      bus.ifu_rsp_hsk = (c % 2 == 0);
      #1 check("drain_drop", bus.ifu_rsp_drop, 1'b1);
      check("drain_block", bus.ifu_req_block, 1'b1);
      check("drain_novalid", bus.redir_valid, 1'b0);
      if (bus.ifu_rsp_hsk) ndrop++;
      step();
    end
    bus.ifu_rsp_hsk = 1'b0;
    check("drain_count", ndrop, 3);
    check("drain_valid", bus.redir_valid, 1'b1);
    check("drain_done", bus.ifu_rsp_drop, 1'b0);
    check("arith_small", bus.redir_pc, 32'h0000_0102);
    bus.redir_ready = 1'b1;
    step();

    // Wrapping target sum
    bus.brchmis_flush_req = 1'b1;
    bus.brchmis_flush_add_op1 = 32'hFFFF_FFF0; bus.brchmis_flush_add_op2 = 32'h0000_0014;
    step();
    bus.brchmis_flush_req = 1'b0;
    check("arith_wrap", bus.redir_pc, 32'h0000_0004);
    step();
    bus.redir_ready = 1'b0;

    // Reset in the middle of a drain
    bus.ifu_req_hsk = 1'b1;
    step();
    step();
    bus.ifu_req_hsk = 1'b0;
    bus.excp_flush_req = 1'b1; bus.excp_flush_pc = 32'h0000_2000;
    step();
    bus.excp_flush_req = 1'b0;
    step();
    check("mid_in_drain", bus.ifu_rsp_drop, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_busy", bus.flush_busy, 1'b0);
    check("mid_drop", bus.ifu_rsp_drop, 1'b0);
    check("mid_valid", bus.redir_valid, 1'b0);
    check("mid_outs", bus.outs_cnt, 2'd0);

    // Random traffic: requests held until acked, fetches kept within legal use
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!bus.brchmis_flush_req && $urandom_range(0, 3) == 0) begin
        bus.brchmis_flush_req = 1'b1;
        bus.brchmis_flush_add_op1 = $urandom;
        bus.brchmis_flush_add_op2 = $urandom;
      end
      if (!bus.excp_flush_req && $urandom_range(0, 7) == 0) begin
        bus.excp_flush_req = 1'b1;
        bus.excp_flush_pc = $urandom;
      end
      bus.ifu_req_hsk = !(m_pending || m_outs == 2) && ($urandom_range(0, 1) == 1);
      bus.ifu_rsp_hsk = (m_outs > 0) && ($urandom_range(0, 1) == 1);
      bus.redir_ready = ($urandom_range(0, 1) == 1);
      step();
      if (exp_br_ack)   bus.brchmis_flush_req = 1'b0;
      if (exp_excp_ack) bus.excp_flush_req = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
